clk_divider_bank: RTL and testbench

- Multi-channel, runtime-programmable clock-enable/divided-clock generator.
- Successor to the fixed-ratio divider used for the audio and system rate clocks (48 kHz, 96 kHz, 24 MHz, 48 MHz derived from the board clock).
- Each channel has its own half-period count, output mode and enable, all in one clock domain.
- Outputs feed downstream logic as square waves or single-cycle strobes. Registers are loaded through a simple write port.

---
 rtl/clk_divider_bank.sv | 98 +++++++++
 tb/tb_clk_divider_bank.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_bank.sv
// ---------------------------------------------------------------------------
// clk_divider_bank
//
// Bank of N_CH independently programmable clock dividers in a single clock
// domain. Each channel counts clk cycles up to a programmable half-period.
// At each half-period boundary it raises a one-cycle tick and updates its
// divided output:
//   mode 0 : square wave, the output toggles at every boundary (period 2*half)
//   mode 1 : pulse train, the output is high for the boundary cycle only
//            (period half)
// A half-period of 0 parks the channel with both outputs low.
//
// Ports
//   clk       in   system clock, all state updates on the rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   [N_CH]  per-channel run enable (level)
//   sync_all  in   one-cycle strobe, restarts the phase of every channel
//   cfg_we    in   configuration write strobe
//   cfg_ch    in   [CH_W]  target channel; indices >= N_CH are ignored
//   cfg_half  in   [CNT_W] new half-period in clk cycles
//   cfg_mode  in   new output mode (0 square, 1 pulse)
//   div_out   out  [N_CH]  per-channel divided output (registered)
//   tick      out  [N_CH]  per-channel boundary strobe (registered)
// ---------------------------------------------------------------------------
module clk_divider_bank #(
    parameter int N_CH         = 4,
    parameter int CNT_W        = 26,
    parameter int DEFAULT_HALF = 24000,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  en,
    input  logic             sync_all,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic             cfg_mode,
    output logic [N_CH-1:0]  div_out,
    output logic [N_CH-1:0]  tick
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] half;
        logic             mode;
        logic             out_q;
        logic             tick_q;
        logic             wr_hit;
        logic             at_end;

        // An out-of-range cfg_ch can never equal a valid channel index, so
        // such writes fall through with no effect on any channel.
        assign wr_hit = cfg_we && (cfg_ch == CH_W'(i));

        // cnt only ever runs 0..half-1, so this compare cannot wrap even
        // for the largest representable half.
        assign at_end = (cnt == half - CNT_W'(1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                half   <= CNT_W'(DEFAULT_HALF);
                mode   <= 1'b0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (sync_all || wr_hit) begin
                // Restart from phase 0; a write also loads the new ratio,
                // which takes effect from the following edge.
                cnt    <= '0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
                if (wr_hit) begin
                    half <= cfg_half;
                    mode <= cfg_mode;
                end
            end else if (!en[i] || (half == '0)) begin
                cnt    <= '0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (at_end) begin
                cnt    <= '0;
                tick_q <= 1'b1;
                out_q  <= mode ? 1'b1 : ~out_q;
            end else begin
                cnt    <= cnt + CNT_W'(1);
                tick_q <= 1'b0;
                if (mode) begin
                    out_q <= 1'b0;
                end
            end
        end

        assign div_out[i] = out_q;
        assign tick[i]    = tick_q;
    end

endmodule

// File: tb/tb_clk_divider_bank.sv
// ---------------------------------------------------------------------------
// tb_clk_divider_bank
//
// Directed and randomized stimulus for clk_divider_bank, checked every cycle
// against a reference model. The model keeps, per channel, the number of
// enabled edges since the last restart (n) and derives the outputs
// arithmetically: a boundary falls on every multiple of half, the square
// output is the parity of n/half, and the pulse output equals the tick.
//
// The DUT is built with five channels so that cfg_ch is three bits wide and
// an out-of-range index such as 5 can actually be presented on the port.
// ---------------------------------------------------------------------------
module tb_clk_divider_bank;

    localparam int N_CH         = 5;
    localparam int CNT_W        = 26;
    localparam int DEFAULT_HALF = 24000;
    localparam int CH_W         = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_CH-1:0]  en = '0;
    logic             sync_all = 1'b0;
    logic             cfg_we = 1'b0;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [CNT_W-1:0] cfg_half = '0;
    logic             cfg_mode = 1'b0;
    logic [N_CH-1:0]  div_out;
    logic [N_CH-1:0]  tick;

    clk_divider_bank #(
        .N_CH         (N_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEFAULT_HALF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_all (sync_all),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_half (cfg_half),
        .cfg_mode (cfg_mode),
        .div_out  (div_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    longint          n_m    [N_CH];
    longint          half_m [N_CH];
    bit              mode_m [N_CH];
    logic [N_CH-1:0] exp_out;
    logic [N_CH-1:0] exp_tick;

    function automatic void model_reset();
        for (int i = 0; i < N_CH; i++) begin
            n_m[i]    = 0;
            half_m[i] = DEFAULT_HALF;
            mode_m[i] = 1'b0;
        end
    endfunction

    // Applies one rising edge using the inputs currently driven.
    function automatic void model_edge();
        for (int i = 0; i < N_CH; i++) begin
            bit wr;
            wr = cfg_we && (int'(cfg_ch) == i);
            if (wr) begin
                half_m[i] = cfg_half;
                mode_m[i] = cfg_mode;
            end
            if (sync_all || wr)
                n_m[i] = 0;
            else if (!en[i] || half_m[i] == 0)
                n_m[i] = 0;
            else
                n_m[i] = n_m[i] + 1;
        end
    endfunction

    function automatic void model_outputs();
        for (int i = 0; i < N_CH; i++) begin
            if (n_m[i] == 0 || half_m[i] == 0) begin
                exp_tick[i] = 1'b0;
                exp_out[i]  = 1'b0;
            end else begin
                exp_tick[i] = (n_m[i] % half_m[i]) == 0;
                exp_out[i]  = mode_m[i] ? exp_tick[i]
                                        : (((n_m[i] / half_m[i]) % 2) == 1);
            end
        end
    endfunction

    task automatic check(input string tag);
        checks++;
        assert (div_out === exp_out) else begin
            errors++;
            $error("FAIL %s div_out observed %b expected %b", tag, div_out, exp_out);
        end
        checks++;
        assert (tick === exp_tick) else begin
            errors++;
            $error("FAIL %s tick observed %b expected %b", tag, tick, exp_tick);
        end
    endtask

    // One clock: the edge is modelled with the inputs held since the previous
    // falling edge, and outputs are compared on the following falling edge.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_outputs();
        check(tag);
    endtask

    task automatic run(input int k, input string tag);
        for (int c = 0; c < k; c++) cyc(tag);
    endtask

    task automatic write(input int ch, input int h, input bit m, input string tag);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_half = CNT_W'(h);
        cfg_mode = m;
        cyc(tag);
        cfg_we   = 1'b0;
    endtask

    initial begin
        // Reset held for three cycles, outputs must stay low.
        model_reset();
        model_outputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("reset");
        end

        // Default ratio on channel 0: rises at edge 24000, falls at 48000.
        rst_n = 1'b1;
        en    = 5'b00001;
        run(48005, "ch0_default");

        // Square on ch1 (half 3), pulse on ch2 (half 4).
        en = '0;
        write(1, 3, 1'b0, "cfg_ch1");
        write(2, 4, 1'b1, "cfg_ch2");
        en = 5'b00110;
        run(30, "ratio");

        // ch3 edge values: idle, clk/2 square, held-high pulse.
        write(3, 0, 1'b0, "cfg_ch3_idle");
        en[3] = 1'b1;
        run(10, "ch3_idle");
        write(3, 1, 1'b0, "cfg_ch3_h1sq");
        run(10, "ch3_h1_square");
        write(3, 1, 1'b1, "cfg_ch3_h1pl");
        run(10, "ch3_h1_pulse");

        // Rewrite ch1 while its output is high.
        begin
            int w = 0;
            while (div_out[1] !== 1'b1 && w < 20) begin
                cyc("wait_ch1");
                w++;
            end
            checks++;
            assert (div_out[1] === 1'b1) else begin
                errors++;
                $error("FAIL wait_ch1_high observed %b expected 1 within 20 cycles", div_out[1]);
            end
        end
        write(1, 5, 1'b0, "cfg_ch1_mid");
        run(25, "ch1_half5");
        en[1] = 1'b0;
        run(3, "ch1_disabled");
        en[1] = 1'b1;
        run(15, "ch1_reenable");

        // Out-of-range channel index must not touch any channel.
        write(5, 1, 1'b1, "cfg_oob5");
        write(7, 0, 1'b0, "cfg_oob7");
        run(10, "after_oob");

        // Phase alignment with sync_all.
        write(0, 4, 1'b0, "cfg_ch0_h4");
        en[0] = 1'b1;
        run(3, "ch0_start");
        write(1, 2, 1'b0, "cfg_ch1_h2");
        run(5, "staggered");
        sync_all = 1'b1;
        cyc("sync_edge");
        sync_all = 1'b0;
        run(20, "aligned");

        // Random traffic: enables, writes (including bad indices) and syncs.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(7) == 0) en = N_CH'($urandom);
            cfg_we   = ($urandom_range(15) == 0);
            cfg_ch   = CH_W'($urandom_range(7));
            cfg_half = CNT_W'($urandom_range(9));
            cfg_mode = 1'($urandom_range(1));
            sync_all = ($urandom_range(31) == 0);
            cyc("random");
        end
        cfg_we   = 1'b0;
        sync_all = 1'b0;
        en       = '1;
        write(4, 2, 1'b0, "cfg_ch4");
        run(12, "all_running");

        // Asynchronous reset between edges, outputs must drop at once.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        model_outputs();
        check("async_rst");
        @(negedge clk);
        check("async_rst_held");
        rst_n = 1'b1;
        run(24005, "post_rst_default");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
